// File: rtl/aes_round_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// aes_round_sequencer : iterative AES cipher controller driving a shared
// external round datapath, fetching round keys over a request/valid handshake.
// Rev 1.0
// ============================================================================
module aes_round_sequencer #(
  parameter int NR  = 10,
  parameter int KIW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   pt,
  output logic           key_req,
  output logic [KIW-1:0] key_idx,
  input  logic           key_valid,
  input  logic [127:0]   key_in,
  output logic [127:0]   rnd_state,
  output logic           rnd_last,
  input  logic [127:0]   rnd_result,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   ct
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_KEY0  = 2'd1;
  localparam logic [1:0] c_ROUND = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [KIW-1:0] c_NR  = KIW'(NR);
  localparam logic [KIW-1:0] c_ONE = KIW'(1);

  generate
    if (NR >= (1 << KIW)) begin : g_kiw_too_narrow
      $error("aes_round_sequencer: KIW cannot hold NR");
    end
    if ((NR != 10) && (NR != 12) && (NR != 14)) begin : g_bad_nr
      $error("aes_round_sequencer: NR must be 10, 12 or 14");
    end
  endgenerate

  logic [1:0]     fsm_q,   fsm_d;
  logic [KIW-1:0] round_q, round_d;
  logic [127:0]   data_q,  data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= c_IDLE;
      round_q <= '0;
      data_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      data_q  <= data_d;
    end
  end

  // The round counter saturates at NR: the last round moves to DONE instead.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    data_d  = data_q;
    case (fsm_q)
      c_IDLE: begin
        if (in_valid) begin
          data_d  = pt;
          round_d = '0;
          fsm_d   = c_KEY0;
        end
      end
      c_KEY0: begin
        if (key_valid) begin
          data_d  = data_q ^ key_in;
          round_d = c_ONE;
          fsm_d   = c_ROUND;
        end
      end
      c_ROUND: begin
        if (key_valid) begin
          data_d = rnd_result;
          if (round_q == c_NR) begin
            fsm_d = c_DONE;
          end else begin
            round_d = round_q + c_ONE;
          end
        end
      end
      c_DONE: begin
        if (out_ready) begin
          fsm_d = c_IDLE;
        end
      end
      default: fsm_d = c_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (fsm_q == c_IDLE);
    key_req   = (fsm_q == c_KEY0) || (fsm_q == c_ROUND);
    key_idx   = (fsm_q == c_ROUND) ? round_q : '0;
    rnd_last  = (fsm_q == c_ROUND) && (round_q == c_NR);
    busy      = (fsm_q != c_IDLE);
    out_valid = (fsm_q == c_DONE);
    rnd_state = data_q;
    ct        = data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_aes_round_sequencer : randomized bench with an AES round/key model,
// exercising NR=10 and NR=14 builds of the sequencer.
// ============================================================================
module tb_aes_round_sequencer;

  localparam int NR = 10;

  typedef logic [127:0] rk_t [16];

  logic         clk, rst;
  logic         in_valid, in_ready, key_req, key_valid, rnd_last, busy, out_valid, out_ready;
  logic [3:0]   key_idx;
  logic [127:0] pt, key_in, rnd_state, rnd_result, ct;

  logic         in_valid14, in_ready14, key_req14, key_valid14, rnd_last14;
  logic         busy14, out_valid14, out_ready14;
  logic [3:0]   key_idx14;
  logic [127:0] pt14, key_in14, rnd_state14, rnd_result14, ct14;

  logic [7:0] sbox_t [256];
  rk_t        rk, rk14;
  int         checks, errors, cyc, kv_duty;
  int         exp_idx, n_cons;
  bit         stall_pend;
  logic [127:0] stall_val;
  logic [127:0] bp_p [4];
  logic [127:0] bp_e [4];
  int           bp_acc [4];

  aes_round_sequencer #(.NR(NR), .KIW(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pt(pt),
    .key_req(key_req), .key_idx(key_idx), .key_valid(key_valid), .key_in(key_in),
    .rnd_state(rnd_state), .rnd_last(rnd_last), .rnd_result(rnd_result), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .ct(ct)
  );

  aes_round_sequencer #(.NR(14), .KIW(4)) u_dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14), .pt(pt14),
    .key_req(key_req14), .key_idx(key_idx14), .key_valid(key_valid14), .key_in(key_in14),
    .rnd_state(rnd_state14), .rnd_last(rnd_last14), .rnd_result(rnd_result14), .busy(busy14),
    .out_valid(out_valid14), .out_ready(out_ready14), .ct(ct14)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Byte i of the block sits at bits [127-8i -: 8]; state[r][c] is byte r+4c.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  task automatic expand128(input logic [127:0] key, output rk_t o);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 16; r++) begin
      if (r < 11) o[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else        o[r] = '0;
    end
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] p, input rk_t keys, input int nr);
    logic [127:0] s;
    s = p ^ keys[0];
    for (int r = 1; r <= nr; r++) s = aes_round(s, keys[r], r == nr);
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  assign key_in       = rk[key_idx];
  assign rnd_result   = aes_round(rnd_state, key_in, rnd_last);
  assign key_in14     = rk14[key_idx14];
  assign rnd_result14 = aes_round(rnd_state14, key_in14, rnd_last14);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    key_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      key_valid = ($urandom_range(99) < kv_duty);
    end
  end

  // Key handshake monitor: index order, last-round flag, and state hold on stalls.
  initial begin
    stall_pend = 0; exp_idx = 0; n_cons = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pend = 0;
      end else begin
        if (stall_pend) check_eq("stall_hold", rnd_state, stall_val);
        stall_pend = 0;
        if (in_valid && in_ready) begin
          exp_idx = 0;
          n_cons  = 0;
        end
        if (key_req && key_valid) begin
          check_eq("key_idx_seq", 128'(key_idx), 128'(exp_idx));
          check_eq("rnd_last", 128'(rnd_last), 128'(exp_idx == NR));
          exp_idx++;
          n_cons++;
        end else if (key_req) begin
          stall_pend = 1;
          stall_val  = rnd_state;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic wait_accept(output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_wait", 128'(in_ready), 128'(1));
    acc = cyc;
  endtask

  task automatic wait_out(output int oc);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("out_wait", 128'(out_valid), 128'(1));
    oc = cyc;
  endtask

  task automatic run_block(input logic [127:0] p, input logic [127:0] e, input string tag,
                           input bit chk_lat);
    int acc, oc;
    in_valid = 1'b1;
    pt = p;
    wait_accept(acc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    pt = {$urandom, $urandom, $urandom, $urandom};
    wait_out(oc);
    check_eq({tag, "_ct"}, ct, e);
    check_eq({tag, "_nkeys"}, 128'(n_cons), 128'(NR + 1));
    if (chk_lat) check_eq({tag, "_latency"}, 128'(oc - acc), 128'(NR + 2));
    @(posedge clk); #1;
  endtask

  task automatic run_nr14();
    int acc, n, maxidx;
    logic [127:0] p, e;
    for (int r = 0; r < 16; r++) rk14[r] = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    e = model_enc(p, rk14, 14);
    in_valid14 = 1'b1;
    pt14 = p;
    @(negedge clk);
    check_eq("nr14_in_ready", 128'(in_ready14), 128'(1));
    acc = cyc;
    @(posedge clk); #1;
    in_valid14 = 1'b0;
    maxidx = 0; n = 0;
    @(negedge clk);
    while (!out_valid14 && n < 200) begin
      if (key_req14 && int'(key_idx14) > maxidx) maxidx = int'(key_idx14);
      @(negedge clk);
      n++;
    end
    check_eq("nr14_out_wait", 128'(out_valid14), 128'(1));
    check_eq("nr14_latency", 128'(cyc - acc), 128'(16));
    check_eq("nr14_max_idx", 128'(maxidx), 128'(14));
    check_eq("nr14_ct", ct14, e);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, oc, n;
    logic [127:0] p1, p2, e1, e2, k;
    checks = 0; errors = 0; kv_duty = 100;
    rst = 1'b1; in_valid = 1'b0; pt = '0; out_ready = 1'b0;
    in_valid14 = 1'b0; pt14 = '0; out_ready14 = 1'b1; key_valid14 = 1'b1;
    build_sbox();
    for (int r = 0; r < 16; r++) begin rk[r] = '0; rk14[r] = '0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 128'(in_ready), 128'(1));
    check_eq("rst_key_req", 128'(key_req), 128'(0));
    check_eq("rst_key_idx", 128'(key_idx), 128'(0));
    check_eq("rst_rnd_last", 128'(rnd_last), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_ct", ct, 128'(0));
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 C.1 vector with key_valid held high
    out_ready = 1'b1;
    expand128(128'h000102030405060708090a0b0c0d0e0f, rk);
    run_block(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              "fips_c1", 1'b1);

    // Random keys and plaintexts with a sparse key handshake
    kv_duty = 30;
    for (int b = 0; b < 3; b++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand128(k, rk);
      p1 = {$urandom, $urandom, $urandom, $urandom};
      run_block(p1, model_enc(p1, rk, NR), "stall", 1'b0);
    end
    kv_duty = 100;

    // Output backpressure with stray in_valid pulses
    out_ready = 1'b0;
    p1 = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    e1 = model_enc(p1, rk, NR);
    e2 = model_enc(p2, rk, NR);
    in_valid = 1'b1; pt = p1;
    wait_accept(acc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(oc);
    check_eq("bp_ct", ct, e1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(1));
      pt = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check_eq("bp_valid_hold", 128'(out_valid), 128'(1));
      check_eq("bp_ct_hold", ct, e1);
      check_eq("bp_in_ready_low", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b1; pt = p2; out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_hs_valid", 128'(out_valid), 128'(1));
    check_eq("bp_hs_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bp_accept_next", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(oc);
    check_eq("bp_ct2", ct, e2);
    @(posedge clk); #1;

    // Back-to-back blocks with in_valid and out_ready held high
    for (int b = 0; b < 4; b++) begin
      bp_p[b] = {$urandom, $urandom, $urandom, $urandom};
      bp_e[b] = model_enc(bp_p[b], rk, NR);
    end
    fork
      begin
        in_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
          pt = bp_p[b];
          wait_accept(bp_acc[b]);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 4; j++) begin
          int ocj;
          wait_out(ocj);
          check_eq("b2b_ct", ct, bp_e[j]);
          @(posedge clk); #1;
        end
      end
    join
    for (int b = 1; b < 4; b++)
      check_eq("b2b_period", 128'(bp_acc[b] - bp_acc[b-1]), 128'(NR + 3));

    // Asynchronous reset during round 5, then a fresh block
    p1 = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; pt = p1;
    wait_accept(acc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(key_req && key_idx == 4'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_mid_reach_r5", 128'(key_idx), 128'(5));
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_in_ready", 128'(in_ready), 128'(1));
    check_eq("rst_mid_key_req", 128'(key_req), 128'(0));
    check_eq("rst_mid_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_mid_ct", ct, 128'(0));
    check_eq("rst_mid_busy", 128'(busy), 128'(0));
    #1 rst = 1'b0;
    @(posedge clk); #1;
    k = {$urandom, $urandom, $urandom, $urandom};
    expand128(k, rk);
    p2 = {$urandom, $urandom, $urandom, $urandom};
    run_block(p2, model_enc(p2, rk, NR), "post_rst", 1'b1);

    run_nr14();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller. It owns the 128-bit cipher state register and sequences one shared external round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) across NR rounds.
- It fetches round keys from the key-schedule store through a request/valid handshake.
- The initial AddRoundKey (pt XOR key0) is performed internally.
- It asserts rnd_last on the final round so the datapath bypasses MixColumns. Its handshaked in/out ports sit between the host interface and the cipher core.

Parameters:
- NR, 10, number of cipher rounds (10/12/14 legal; key width stays 128 per round key).
- KIW, 4, width of key_idx (must hold NR).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  plaintext offered
- in_ready  out  1  sequencer idle, accepts plaintext
- pt  in  128  plaintext, sampled on in_valid&&in_ready
- key_req  out  1  round key requested
- key_idx  out  KIW  index of requested round key (0..NR)
- key_valid  in  1  key_in holds key[key_idx]; consumed same cycle
- key_in  in  128  round key, also routed to datapath by top level
- rnd_state  out  128  current state register, drives datapath input
- rnd_last  out  1  final round: datapath must skip MixColumns
- rnd_result  in  128  combinational datapath output for rnd_state/key_in
- busy  out  1  high in any state except IDLE
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- ct  out  128  ciphertext (= state register)

Behaviour:
- Reset (async, any time including mid-operation): FSM=IDLE, round=0, state reg=0.
  - Outputs: in_ready=1, key_req=0, key_idx=0, rnd_last=0, busy=0, out_valid=0, ct=0.
  - Any in-flight block is discarded.
- FSM states: IDLE, KEY0, ROUND, DONE.
- IDLE: in_ready=1.
  - On in_valid: state<=pt, round<=0, go KEY0.
  - in_valid while not IDLE is ignored; the source holds it.
- KEY0: key_req=1, key_idx=0.
  - On key_valid: state<=state^key_in, round<=1, go ROUND.
  - Without key_valid: hold, no state change.
- ROUND: key_req=1, key_idx=round, rnd_last=(round==NR).
  - On key_valid: state<=rnd_result.
  - If round==NR, go DONE; else round<=round+1.
  - Stalls indefinitely while key_valid=0.
- DONE: out_valid=1, ct=state, held stable until out_ready.
  - On out_ready: go IDLE; state register retains value.
  - in_ready stays 0 in DONE, so there is no same-cycle accept. The next block can be accepted the cycle after the out handshake.
- key_valid is ignored whenever key_req=0. key_req deasserts in the same cycle FSM leaves ROUND.
- rnd_state always equals the state register; it is combinational-free (registered).
- Latency with key_valid tied high:
  - accept at cycle T, KEY0 at T+1, rounds 1..NR at T+2..T+NR+1, out_valid at T+NR+2.
  - For NR=10 that is 12 cycles.
- Throughput with key_valid and out_ready tied high: one block per NR+3 cycles.
- round counter never exceeds NR and never wraps. key_idx width is checked: NR < 2**KIW.

Test Plan:
- FIPS-197 C.1: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, bench key store plus reference round model -> ct=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 12 cycles after accept; key_idx sequence 0,1,...,10; rnd_last high only at key_idx=10.
- Key stalls: key_valid random 30% duty -> same ct; state register unchanged in every cycle with key_req&&!key_valid; key_idx never skips or repeats after a consume.
- Output backpressure: out_ready low 20 cycles -> out_valid and ct stable; in_ready=0 throughout; in_valid pulses ignored; block accepted the cycle after out_ready handshake.
- Back-to-back: 4 blocks with in_valid and out_ready held high -> accepts every 13 cycles; all ct match model.
- Reset mid-op: assert rst during round 5 -> immediately in_ready=1, key_req=0, out_valid=0, ct=0; next block encrypts correctly.
- NR=14 build: 14-round vector with bench model -> key_idx reaches 14; out_valid at 16 cycles after accept.
